// File: rtl/usr_pkg.sv
// Shared definitions for the shift-register family: mode encodings, receive FSM states
// and bit-order constants.
package usr_pkg;

    localparam logic [1:0] HOLD        = 2'b00;
    localparam logic [1:0] SHIFT_RIGHT = 2'b01;
    localparam logic [1:0] SHIFT_LEFT  = 2'b10;
    localparam logic [1:0] LOAD        = 2'b11;

    localparam logic MSB_FIRST = 1'b1;
    localparam logic LSB_FIRST = 1'b0;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } rx_state_e;

    function automatic logic [1:0] shift_mode(input logic dir);
        return (dir == MSB_FIRST) ? SHIFT_LEFT : SHIFT_RIGHT;
    endfunction

endpackage

// File: rtl/rx_shift_core.sv
// Bit assembler: shift register, per-frame direction latch and bit counter; pulses word_done
// with the completed word in the cycle the last bit is accepted. No backpressure (always accepts).
module rx_shift_core
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             msb_first,
    output logic             word_done,
    output logic [WIDTH-1:0] word,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    rx_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             dir_q, dir_d;
    logic             dir_eff;
    logic [1:0]       mode;

    // The first bit of a frame shifts using the live msb_first; later bits use the latched one.
    assign dir_eff = (state_q == IDLE) ? msb_first : dir_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = IDLE;
        end else if (s_valid) begin
            case (state_q)
                IDLE:    state_d = RECV;
                RECV:    state_d = (cnt_q == LAST) ? IDLE : RECV;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy      = (state_q == RECV);
        word_done = s_valid && !clear && (cnt_q == LAST);
    end

    always_comb begin
        mode = HOLD;
        if (clear) begin
            mode = LOAD;
        end else if (s_valid) begin
            mode = shift_mode(dir_eff);
        end
    end

    always_comb begin
        case (mode)
            SHIFT_LEFT:  shreg_d = {shreg_q[WIDTH-2:0], s_data};
            SHIFT_RIGHT: shreg_d = {s_data, shreg_q[WIDTH-1:1]};
            LOAD:        shreg_d = '0;
            default:     shreg_d = shreg_q;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        dir_d = dir_q;
        if (clear) begin
            cnt_d = '0;
        end else if (s_valid) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
            if (state_q == IDLE) begin
                dir_d = msb_first;
            end
        end
    end

    // The completed word includes the bit arriving this cycle.
    assign word = shreg_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            dir_q   <= MSB_FIRST;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: rtl/usr_deserializer.sv
// Serial-to-parallel receiver with a one-word holding register; word valid one cycle after last bit.
// A word completing while the held word is unconsumed is dropped and sets sticky overrun.
module usr_deserializer
    import usr_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic             s_data,
    input  logic             msb_first,
    input  logic             clear,
    output logic [WIDTH-1:0] p_data,
    output logic             p_valid,
    input  logic             p_ready,
    output logic             busy,
    output logic             overrun
);

    logic             word_done;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] p_data_q, p_data_d;
    logic             p_valid_q, p_valid_d;
    logic             overrun_q, overrun_d;

    rx_shift_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .msb_first(msb_first),
        .word_done(word_done),
        .word     (word),
        .busy     (busy)
    );

    always_comb begin
        p_data_d  = p_data_q;
        p_valid_d = p_valid_q;
        overrun_d = overrun_q;
        if (clear) begin
            p_valid_d = 1'b0;
            overrun_d = 1'b0;
        end else if (word_done) begin
            // A consumer handshake on the completion edge frees the slot for the new word.
            if (!p_valid_q || p_ready) begin
                p_data_d  = word;
                p_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (p_valid_q && p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_data_q  <= '0;
            p_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            p_data_q  <= p_data_d;
            p_valid_q <= p_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign p_data  = p_data_q;
    assign p_valid = p_valid_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_usr_deserializer.sv
// Self-checking bench for usr_deserializer: directed scenarios plus randomized traffic
// compared against a queue-based frame model.
module tb_usr_deserializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         s_valid = 1'b0, s_data = 1'b0, msb_first = 1'b0, clear = 1'b0, p_ready = 1'b0;
    logic [W-1:0] p_data;
    logic         p_valid, busy, overrun;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: bits of the frame in arrival order, plus the holding slot.
    logic         m_bits[$];
    logic         m_dir;
    logic [W-1:0] m_data;
    logic         m_valid, m_ovr;

    usr_deserializer #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_data   (s_data),
        .msb_first(msb_first),
        .clear    (clear),
        .p_data   (p_data),
        .p_valid  (p_valid),
        .p_ready  (p_ready),
        .busy     (busy),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] obs();
        return {p_valid, p_data, busy, overrun};
    endfunction

    function automatic logic [6:0] model_obs();
        return {m_valid, m_data, (m_bits.size() != 0), m_ovr};
    endfunction

    // First bit is most significant when msb-first; otherwise bit i has weight 2**i.
    function automatic logic [W-1:0] model_word(input logic dir);
        int v = 0;
        for (int i = 0; i < W; i++) begin
            if (dir) v = v * 2 + int'(m_bits[i]);
            else     v = v + (int'(m_bits[i]) << i);
        end
        return W'(v);
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_dir   = 1'b1;
        m_data  = '0;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic model_step();
        logic         done;
        logic [W-1:0] w;
        done = 1'b0;
        w    = '0;
        if (clear) begin
            m_bits.delete();
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end else begin
            if (s_valid) begin
                if (m_bits.size() == 0) m_dir = msb_first;
                m_bits.push_back(s_data);
                if (m_bits.size() == W) begin
                    w    = model_word(m_dir);
                    done = 1'b1;
                    m_bits.delete();
                end
            end
            if (done) begin
                if (!m_valid || p_ready) begin
                    m_data  = w;
                    m_valid = 1'b1;
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && p_ready) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic tick(input logic sv, input logic sd, input logic msb, input logic clr,
                        input logic rdy);
        s_valid   = sv;
        s_data    = sd;
        msb_first = msb;
        clear     = clr;
        p_ready   = rdy;
        @(posedge clk);
        model_step();
        #1;
        s_valid = 1'b0;
        clear   = 1'b0;
        p_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] w, input logic dir, input logic rdy_last);
        for (int i = 0; i < W; i++) begin
            tick(1'b1, dir ? w[W-1-i] : w[i], dir, 1'b0, (i == W - 1) ? rdy_last : 1'b0);
        end
    endtask

    task automatic test_reset();
        logic [6:0] exp;
        model_reset();
        #2;
        exp = 7'b0_0000_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_state: got %b want %b", obs(), exp);
        end
        #5 rst = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL after_reset_release: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_msb_first();
        logic [3:0] bits;
        logic [6:0] exp;
        bits = 4'b1011;
        for (int i = 0; i < 3; i++) begin
            tick(1'b1, bits[3-i], 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (busy !== 1'b1 || p_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL msb_busy_bit%0d: got busy=%b p_valid=%b want busy=1 p_valid=0",
                         i + 1, busy, p_valid);
            end
        end
        tick(1'b1, bits[0], 1'b1, 1'b0, 1'b0);
        exp = 7'b1_1011_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL msb_word: got %b want %b", obs(), exp);
        end
        tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        exp = 7'b0_1011_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL msb_consume: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_lsb_first();
        logic [6:0] exp;
        tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        exp = 7'b1_1101_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL lsb_word: got %b want %b", obs(), exp);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        logic [6:0] exp;
        bits = 4'b0110;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1, bits[3-i], 1'b1, 1'b0, 1'b0);
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
                    n_checks++;
                    if (busy !== 1'b1) begin
                        n_fail++;
                        $display("FAIL gap_busy bit%0d gap%0d: got %b want 1", i + 1, g, busy);
                    end
                end
            end
        end
        exp = 7'b1_0110_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL gap_word: got %b want %b", obs(), exp);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_backpressure();
        logic [6:0] exp;
        send_frame(4'hA, 1'b1, 1'b0);
        send_frame(4'h5, 1'b1, 1'b0);
        exp = 7'b1_1010_0_1;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL backpressure_hold: got %b want %b", obs(), exp);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp = 7'b0_1010_0_1;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL backpressure_drain: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_clear();
        logic [6:0] exp;
        send_frame(4'h3, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        exp = 7'b0_0011_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL clear_abort: got %b want %b", obs(), exp);
        end
        send_frame(4'hC, 1'b1, 1'b0);
        exp = 7'b1_1100_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL clear_next_frame: got %b want %b", obs(), exp);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        logic [6:0] exp;
        send_frame(4'hA, 1'b1, 1'b0);
        exp = 7'b1_1010_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL b2b_first: got %b want %b", obs(), exp);
        end
        send_frame(4'h5, 1'b1, 1'b1);
        exp = 7'b1_0101_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL b2b_simul_handshake: got %b want %b", obs(), exp);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        exp = 7'b0_0101_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL b2b_consume: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_reset_midframe();
        logic [6:0] exp;
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1;
        model_reset();
        exp = 7'b0_0000_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_midframe: got %b want %b", obs(), exp);
        end
        #3 rst = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        send_frame(4'h7, 1'b1, 1'b0);
        exp = 7'b1_0111_0_0;
        n_checks++;
        if (obs() !== exp) begin
            n_fail++;
            $display("FAIL reset_new_frame: got %b want %b", obs(), exp);
        end
    endtask

    task automatic test_random();
        logic sv, sd, msb, clr, rdy;
        for (int c = 0; c < 600; c++) begin
            sv  = ($urandom_range(0, 9) < 7);
            sd  = 1'($urandom);
            msb = 1'($urandom);
            clr = ($urandom_range(0, 49) == 0);
            rdy = ($urandom_range(0, 9) < 4);
            tick(sv, sd, msb, clr, rdy);
            n_checks++;
            if (obs() !== model_obs()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %b want %b", c, obs(), model_obs());
            end
        end
    endtask

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_gaps();
        test_backpressure();
        test_clear();
        test_back_to_back();
        test_reset_midframe();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usr_deserializer.md
# usr_deserializer

Serial-to-parallel receiver forming the far end of a shift-register serial link: accepts one bit per strobe, assembles `WIDTH`-bit words in either MSB-first (shift-left) or LSB-first (shift-right) order, and presents each completed word through a valid/ready handshake. A one-word holding register lets the next frame be received while the previous word waits for the consumer. Sticky overrun reporting covers lost words.

## Interface
- `WIDTH`, default 4: word width in bits; legal range is 2 or more.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `s_valid`  in  1: serial bit strobe; `s_data` is accepted on every edge where this is high.
- `s_data`  in  1: serial data bit.
- `msb_first`  in  1: bit order; 1 = shift-left (first bit ends at `[WIDTH-1]`), 0 = shift-right (first bit ends at `[0]`).
- `clear`  in  1: synchronous abort; discards the partial frame, the held word and the overrun flag.
- `p_data`  out  WIDTH: received word, stable while `p_valid` is high.
- `p_valid`  out  1: holding register contains an unconsumed word.
- `p_ready`  in  1: consumer accepts `p_data` on an edge where `p_valid` and `p_ready` are both high.
- `busy`  out  1: partial frame in progress (bit count 1..WIDTH-1).
- `overrun`  out  1: sticky flag; a completed word was dropped.

## Operation
- The receive FSM has two states: IDLE (count 0) and RECV (count 1..WIDTH-1). `busy` = (state == RECV).
- When `s_valid` is high in IDLE, `msb_first` is latched into a direction register for the whole frame. `msb_first` changes mid-frame are ignored.
- Shift-left update: `shreg <= {shreg[WIDTH-2:0], s_data}`. Shift-right update: `shreg <= {s_data, shreg[WIDTH-1:1]}`.
- The bit counter increments only on accepted bits. When `s_valid` is low, shreg and count hold, so gaps of any length are legal.
- When the WIDTH-th bit is accepted, the FSM returns to IDLE and the count wraps to 0. In the same cycle, the next word (shreg including the new bit) is offered to the holding register.
- Holding-register update on a completion edge:
  - If `p_valid` is 0, or if `p_valid` and `p_ready` are both 1, load the word and set `p_valid` = 1.
  - If `p_valid` is 1 and `p_ready` is 0, drop the new word, keep `p_data`, and set `overrun` = 1.
- Handshake with no completion: when `p_valid` and `p_ready` are both high, `p_valid` clears next cycle. `p_data` keeps its last value and is not zeroed.
- `clear` has priority over all other inputs. Next cycle: count = 0, state = IDLE, `p_valid` = 0, `overrun` = 0. Bits strobed in the `clear` cycle are discarded.
- `overrun` clears only on `clear` or reset.

## Timing
- Reset values (asynchronous, while `rst` = 0): `p_data` = 0, `p_valid` = 0, `busy` = 0, `overrun` = 0, shreg = 0, count = 0, FSM = IDLE, direction = MSB-first.
- If reset asserts mid-frame, the partial frame is lost. The first bit after `rst` deasserts starts a new frame.
- Latency: the last bit is accepted at edge N; `p_valid` and `p_data` are valid after edge N, i.e. one cycle.
- Maximum throughput is one bit per cycle, which gives back-to-back words every WIDTH cycles with no dead cycle between frames.
- `busy` goes high after the first accepted bit and low after the WIDTH-th bit is accepted.
- `p_ready` has no combinational path to any output. All outputs are registered.

## Structure
- Shared package `usr_pkg` holds:
  - The 2-bit mode encodings used across the shift-register family: HOLD = 2'b00, SHIFT_RIGHT = 2'b01, SHIFT_LEFT = 2'b10, LOAD = 2'b11.
  - The FSM state typedef (IDLE, RECV).
  - The direction constants MSB_FIRST = 1'b1 and LSB_FIRST = 1'b0.
- Sub-module `rx_shift_core` contains shreg, the direction register and the bit counter. It outputs a one-cycle `word_done` pulse and the word.
- The top level owns the holding register, the handshake and `overrun`.

## Test plan
- Reset and MSB-first frame (WIDTH = 4): hold `rst` low, then send 1,0,1,1 on consecutive cycles with `msb_first` = 1 → `p_data` = 4'b1011 and `p_valid` = 1 one cycle after the 4th bit; `busy` is high for cycles 2–4.
- LSB-first: send 1,0,1,1 with `msb_first` = 0 → `p_data` = 4'b1101. Toggling `msb_first` after bit 1 has no effect.
- Gaps: send 0,1,1,0 with 3 idle cycles between bits → `p_data` = 4'b0110 (MSB-first); `busy` holds throughout the gaps.
- Back-pressure: with `p_ready` = 0, send frame 4'hA then frame 4'h5 → `p_data` stays 4'hA and `overrun` = 1. Then set `p_ready` = 1 → `p_valid` drops and `overrun` stays 1.
- Simultaneous handshake: 4'hA is held, and `p_ready` = 1 on the same edge that frame 4'h5 completes → no overrun; `p_data` = 4'h5 and `p_valid` = 1 the next cycle.
- Abort: pulse `clear` after 2 bits of a frame and while `overrun` = 1 → `busy` = 0, `p_valid` = 0, `overrun` = 0. The following 4 bits 1,1,0,0 yield `p_data` = 4'hC. Asserting `rst` mid-frame gives all outputs = 0 immediately.
